commit_ring_mw: RTL and testbench
=================================

Name: commit_ring_mw

Overview:
- Multi-wide, parametrised successor of the in-order commit ring. Records the commit class of each issued instruction in program order.
- Presents up to COMMIT_W oldest entries per cycle to the commit units (GPR/FPR/SW/OUT/B) and retires them in order.
- Adds per-slot issue tags, occupancy count, full-capacity use and branch-mispredict squash.
- Sits between the issue stage and the register-file, store and output commit logic.

Parameters:
- DEPTH_LOG2, 4, log2 of ring entries (N = 2**DEPTH_LOG2).
- ISSUE_W, 2, issue slots per cycle (1..N).
- COMMIT_W, 2, commit slots per cycle (1..N).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- issue_valid  in  ISSUE_W  per-slot issue request; slot 0 is the oldest
- issue_type  in  ISSUE_W x commit_ring_entry  class per slot
- issue_ready  out  ISSUE_W  slot k may be accepted
- issue_tag  out  ISSUE_W x DEPTH_LOG2  ring index slot k would occupy
- commit_valid  out  COMMIT_W  head+k holds a committable entry
- commit_type  out  COMMIT_W x commit_ring_entry  class at head+k
- commit_ready  in  COMMIT_W  consumer accepts slot k
- commit_tag  out  COMMIT_W x DEPTH_LOG2  ring index of head+k
- flush_valid  in  1  squash entries younger than flush_tag (feature only)
- flush_tag  in  DEPTH_LOG2  index of the mispredicted branch, kept
- empty  out  1  count == 0
- full  out  1  count == N
- count  out  DEPTH_LOG2+1  occupied entries
- in_count  out  DEPTH_LOG2+1  live entries of class COMMIT_GPR_IN or COMMIT_FPR_IN

Behaviour:
- State:
  - issue_ptr and commit_ptr, each DEPTH_LOG2 bits, wrap modulo N.
  - count register, DEPTH_LOG2+1 bits. All N entries are usable; no empty-slot sacrifice.
  - entry[N], each commit_ring_entry.
- Reset: while reset_n == 0 at a clk edge, both pointers = 0, count = 0 and every entry = COMMIT_NULL. Reset overrides issue, commit and flush. After reset:
  - empty = 1, full = 0, in_count = 0.
  - issue_ready = all ones (if N >= ISSUE_W).
  - commit_valid = 0.
- Issue:
  - issue_ready[k] = (N - count) > k, derived from the registered count only. Space freed by a commit in the same cycle is not reusable that cycle.
  - With the feature compiled in, issue_ready is forced to 0 while flush_valid = 1.
  - Slot k is accepted iff issue_valid[j] && issue_ready[j] for all j <= k. Acceptance is a contiguous prefix; a gap stops acceptance.
  - entry[issue_ptr+k] <= issue_type[k]. issue_ptr advances by the number accepted.
  - issue_tag[k] = issue_ptr + k, modulo N.
- Commit:
  - commit_valid[k] = (count > k) && entry[commit_ptr+k] != COMMIT_NULL.
  - commit_type[k] = entry[commit_ptr+k]. commit_tag[k] = commit_ptr + k.
  - Retired = the leading prefix of slots with commit_valid && commit_ready.
  - Each retired entry becomes COMMIT_NULL. commit_ptr advances by the number retired.
- Single-cycle latency: an entry issued at edge t is visible as commit_valid[0] in the cycle after edge t, if it is at the head.
- Count update: count_next = count + issued - retired. The bounds hold by construction; count never exceeds N or underflows.
- Same-index issue and commit cannot occur because issue uses the pre-commit count. Assert this in simulation.
- in_count is combinational over entry[]. Its width is DEPTH_LOG2+1, so it cannot overflow at N.
- Wrap-around: pointer and tag arithmetic is modulo N. count distinguishes full from empty.

Optional Feature:
- COMMIT_RING_FLUSH_EN defined:
  - flush_valid squashes every entry strictly younger than flush_tag.
  - Squashed entries become COMMIT_NULL.
  - issue_ptr <= flush_tag + 1.
  - count_next = ((flush_tag - commit_ptr) mod N) + 1 - retired.
  - The flush_tag entry itself may retire in the same cycle.
  - flush_tag must name a live entry; assert this in simulation.
- Undefined: the flush ports are absent and there is no squash logic.

Decomposition:
- Package commit_pkg holds:
  - commit_ring_entry enum: COMMIT_NULL, COMMIT_GPR, COMMIT_GPR_IN, COMMIT_FPR, COMMIT_FPR_IN, COMMIT_SW, COMMIT_OUT, COMMIT_B, COMMIT_X.
  - Default parameter constants.
- Sub-module prefix_accept (parameter W): valid/ready vectors in, one-hot-prefix mask and popcount out. Instantiated twice, once for issue and once for commit.

Test Plan:
- Reset, then issue {GPR, FPR} in one cycle -> issue_tag = {0, 1}; next cycle count = 2, commit_type = {GPR, FPR}, commit_valid = 2'b11.
- commit_ready = 2'b10 with both valid -> nothing retires, because slot 0 is not ready; count stays 2.
- Issue 16 entries with no commits (N = 16) -> full = 1, count = 16, issue_ready = 0.
  - Then retire 2 -> no issue in the retire cycle; issue_ready = 2'b11 the following cycle.
- Fill 10 GPR_IN/FPR_IN entries after pointers have wrapped past index 15 -> in_count = 10; it decrements as the entries retire.
- With COMMIT_RING_FLUSH_EN: 8 entries at tags 3..10, flush_tag = 5, commit slot 0 retiring in the same cycle -> issue_ptr = 6, count = 2, entries 6..10 = COMMIT_NULL.
- reset_n low mid-operation with full ring and commit_ready high -> next cycle empty = 1, count = 0, in_count = 0, no retire pulse.

Source files
------------

// File: rtl/commit_pkg.sv
// Shared types for the multi-wide commit ring: the entry class enum and
// default sizing constants.
package commit_pkg;

    typedef enum logic [3:0] {
        COMMIT_NULL   = 4'd0,
        COMMIT_GPR    = 4'd1,
        COMMIT_GPR_IN = 4'd2,
        COMMIT_FPR    = 4'd3,
        COMMIT_FPR_IN = 4'd4,
        COMMIT_SW     = 4'd5,
        COMMIT_OUT    = 4'd6,
        COMMIT_B      = 4'd7,
        COMMIT_X      = 4'd8
    } commit_ring_entry;

    localparam int DEPTH_LOG2_DEF = 4;
    localparam int ISSUE_W_DEF    = 2;
    localparam int COMMIT_W_DEF   = 2;

endpackage

// File: rtl/commit_ring_mw_if.sv
// Issue / commit / status bundle of the commit ring.
// The flush pair exists only when COMMIT_RING_FLUSH_EN is defined.
interface commit_ring_mw_if #(
    parameter int DEPTH_LOG2 = commit_pkg::DEPTH_LOG2_DEF,
    parameter int ISSUE_W    = commit_pkg::ISSUE_W_DEF,
    parameter int COMMIT_W   = commit_pkg::COMMIT_W_DEF
);
    import commit_pkg::*;

    logic [ISSUE_W-1:0]                     issue_valid;
    commit_ring_entry [ISSUE_W-1:0]         issue_type;
    logic [ISSUE_W-1:0]                     issue_ready;
    logic [ISSUE_W-1:0][DEPTH_LOG2-1:0]     issue_tag;
    logic [COMMIT_W-1:0]                    commit_valid;
    commit_ring_entry [COMMIT_W-1:0]        commit_type;
    logic [COMMIT_W-1:0]                    commit_ready;
    logic [COMMIT_W-1:0][DEPTH_LOG2-1:0]    commit_tag;
`ifdef COMMIT_RING_FLUSH_EN
    logic                                   flush_valid;
    logic [DEPTH_LOG2-1:0]                  flush_tag;
`endif
    logic                                   empty;
    logic                                   full;
    logic [DEPTH_LOG2:0]                    count;
    logic [DEPTH_LOG2:0]                    in_count;

`ifdef COMMIT_RING_FLUSH_EN
    modport master (output issue_valid, issue_type, commit_ready, flush_valid, flush_tag,
                    input  issue_ready, issue_tag, commit_valid, commit_type, commit_tag,
                           empty, full, count, in_count);
    modport slave  (input  issue_valid, issue_type, commit_ready, flush_valid, flush_tag,
                    output issue_ready, issue_tag, commit_valid, commit_type, commit_tag,
                           empty, full, count, in_count);
`else
    modport master (output issue_valid, issue_type, commit_ready,
                    input  issue_ready, issue_tag, commit_valid, commit_type, commit_tag,
                           empty, full, count, in_count);
    modport slave  (input  issue_valid, issue_type, commit_ready,
                    output issue_ready, issue_tag, commit_valid, commit_type, commit_tag,
                           empty, full, count, in_count);
`endif

endinterface

// File: rtl/prefix_accept.sv
// Contiguous-prefix handshake: slot k fires only if every slot 0..k has
// valid && ready. Returns the firing mask and its population count.
module prefix_accept #(
    parameter int W  = 2,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  valid_i,
    input  logic [W-1:0]  ready_i,
    output logic [W-1:0]  mask_o,
    output logic [CW-1:0] cnt_o
);

    logic run;

    // Walk from the oldest slot; the first gap stops everything after it.
    always_comb begin
        run    = 1'b1;
        mask_o = '0;
        cnt_o  = '0;
        for (int k = 0; k < W; k++) begin
            run       = run & valid_i[k] & ready_i[k];
            mask_o[k] = run;
            cnt_o     = cnt_o + CW'(run);
        end
    end

endmodule

// File: rtl/commit_ring_mw.sv
// Multi-wide in-order commit ring. Records the commit class of issued
// instructions and presents the COMMIT_W oldest to the commit units.
// All 2**DEPTH_LOG2 entries usable; a count register separates full/empty.
// Optional branch-mispredict squash: define COMMIT_RING_FLUSH_EN.
module commit_ring_mw
    import commit_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int ISSUE_W    = ISSUE_W_DEF,
    parameter int COMMIT_W   = COMMIT_W_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    commit_ring_mw_if.slave bus
);

    localparam int N     = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam int ICW   = $clog2(ISSUE_W + 1);
    localparam int CCW   = $clog2(COMMIT_W + 1);

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [CNT_W-1:0]      cnt_t;

    commit_ring_entry    entry_q [N];
    commit_ring_entry    entry_d [N];
    ptr_t                iptr_q, iptr_d, cptr_q, cptr_d;
    cnt_t                count_q, count_d;
    cnt_t                free_slots, in_cnt;
    logic [ISSUE_W-1:0]  iready, imask;
    logic [ICW-1:0]      icnt;
    logic [COMMIT_W-1:0] cready, cmask;
    logic [CCW-1:0]      ccnt;
    logic                flush_act;

    // Issue side only sees the registered count, so a slot freed by a
    // commit this cycle is not reused until the next one.
    assign free_slots = cnt_t'(N) - count_q;

`ifdef COMMIT_RING_FLUSH_EN
    ptr_t fage;  // age of the kept branch relative to the head
    assign flush_act = bus.flush_valid;
    assign fage      = bus.flush_tag - cptr_q;
`else
    assign flush_act = 1'b0;
`endif

    for (genvar k = 0; k < ISSUE_W; k++) begin : g_iss
        assign bus.issue_tag[k] = iptr_q + ptr_t'(k);
        assign iready[k]        = (free_slots > cnt_t'(k)) && !flush_act;
    end
    assign bus.issue_ready = iready;

    for (genvar k = 0; k < COMMIT_W; k++) begin : g_com
        assign bus.commit_tag[k]   = cptr_q + ptr_t'(k);
        assign bus.commit_type[k]  = entry_q[bus.commit_tag[k]];
        assign bus.commit_valid[k] = (count_q > cnt_t'(k)) &&
                                     (entry_q[bus.commit_tag[k]] != COMMIT_NULL);
`ifdef COMMIT_RING_FLUSH_EN
        // Entries younger than the kept branch are being squashed; they must
        // not retire alongside it.
        assign cready[k] = bus.commit_ready[k] && (!flush_act || ptr_t'(k) <= fage);
`else
        assign cready[k] = bus.commit_ready[k];
`endif
    end

    prefix_accept #(.W(ISSUE_W)) u_issue_acc (
        .valid_i (bus.issue_valid),
        .ready_i (iready),
        .mask_o  (imask),
        .cnt_o   (icnt)
    );

    prefix_accept #(.W(COMMIT_W)) u_commit_acc (
        .valid_i (bus.commit_valid),
        .ready_i (cready),
        .mask_o  (cmask),
        .cnt_o   (ccnt)
    );

    // Next ring state: retire, then write new entries, then optional squash.
    always_comb begin
        entry_d = entry_q;
        for (int k = 0; k < COMMIT_W; k++)
            if (cmask[k]) entry_d[bus.commit_tag[k]] = COMMIT_NULL;
        for (int k = 0; k < ISSUE_W; k++)
            if (imask[k]) entry_d[bus.issue_tag[k]] = bus.issue_type[k];
        cptr_d  = cptr_q + ptr_t'(ccnt);
        iptr_d  = iptr_q + ptr_t'(icnt);
        count_d = count_q + cnt_t'(icnt) - cnt_t'(ccnt);
`ifdef COMMIT_RING_FLUSH_EN
        if (flush_act) begin
            for (int i = 0; i < N; i++) begin
                if ((cnt_t'(ptr_t'(i) - cptr_q) < count_q) && ((ptr_t'(i) - cptr_q) > fage))
                    entry_d[i] = COMMIT_NULL;
            end
            iptr_d  = bus.flush_tag + ptr_t'(1);
            count_d = cnt_t'(fage) + cnt_t'(1) - cnt_t'(ccnt);
        end
`endif
    end

    // Ring state registers; reset wins over every other update.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            iptr_q  <= '0;
            cptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < N; i++) entry_q[i] <= COMMIT_NULL;
        end else begin
            iptr_q  <= iptr_d;
            cptr_q  <= cptr_d;
            count_q <= count_d;
            entry_q <= entry_d;
        end
    end

    // Live count of input-class entries; dead slots always hold COMMIT_NULL.
    always_comb begin
        in_cnt = '0;
        for (int i = 0; i < N; i++)
            if (entry_q[i] == COMMIT_GPR_IN || entry_q[i] == COMMIT_FPR_IN)
                in_cnt = in_cnt + cnt_t'(1);
    end

    assign bus.empty    = (count_q == '0);
    assign bus.full     = (count_q == cnt_t'(N));
    assign bus.count    = count_q;
    assign bus.in_count = in_cnt;

    // Issue and retire never touch the same slot; a flush must keep a live entry.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int k = 0; k < ISSUE_W; k++)
                for (int j = 0; j < COMMIT_W; j++)
                    if (imask[k] && cmask[j])
                        assert (bus.issue_tag[k] != bus.commit_tag[j]);
`ifdef COMMIT_RING_FLUSH_EN
            if (flush_act) assert (cnt_t'(fage) < count_q);
`endif
        end
    end

endmodule

// File: tb/tb_commit_ring_mw.sv
// Scoreboard bench for commit_ring_mw (N=16, ISSUE_W=2, COMMIT_W=2).
// Stimulus pushes expected retirements and per-cycle status; a negedge
// monitor pops and compares.
module tb_commit_ring_mw;
    import commit_pkg::*;

    typedef struct { int cyc; int cnt; int emp; int ful; int inc; int ir; int cv; int tag0; } stat_t;
    typedef struct { commit_ring_entry t; int tag; } ret_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   itag_m = 0;
    bit   done = 1'b0;
    bit   mon_done = 1'b0;
    stat_t stat_q[$];
    ret_t  exp_q[$];
    stat_t s;
    ret_t  r;

    commit_ring_mw_if #(.DEPTH_LOG2(4), .ISSUE_W(2), .COMMIT_W(2)) bus ();

    commit_ring_mw #(.DEPTH_LOG2(4), .ISSUE_W(2), .COMMIT_W(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: status checks for this cycle, then retirement scoreboard.
    always @(negedge clk) begin
        while (stat_q.size() > 0 && stat_q[0].cyc <= cyc) begin
            s = stat_q.pop_front();
            chk("count",       int'(bus.count),        s.cnt);
            chk("empty",       int'(bus.empty),        s.emp);
            chk("full",        int'(bus.full),         s.ful);
            chk("in_count",    int'(bus.in_count),     s.inc);
            chk("issue_ready", int'(bus.issue_ready),  s.ir);
            chk("commit_valid",int'(bus.commit_valid), s.cv);
            chk("issue_tag0",  int'(bus.issue_tag[0]), s.tag0);
            chk("issue_tag1",  int'(bus.issue_tag[1]), (s.tag0 + 1) % 16);
        end
        if (reset_n) begin
            for (int k = 0; k < 2; k++) begin
                if (!(bus.commit_valid[k] && bus.commit_ready[k])) break;
                if (exp_q.size() == 0) begin
                    chk("retire_unexpected", int'(bus.commit_tag[k]), -1);
                end else begin
                    r = exp_q.pop_front();
                    chk("retire_type", int'(bus.commit_type[k]), int'(r.t));
                    chk("retire_tag",  int'(bus.commit_tag[k]),  r.tag);
                end
            end
        end
        if (done && !mon_done) begin
            chk("retire_leftover", exp_q.size(), 0);
            chk("status_leftover", stat_q.size(), 0);
            mon_done = 1'b1;
        end
    end

    task automatic drive(input logic [1:0] v, input commit_ring_entry t0, input commit_ring_entry t1,
                         input logic [1:0] rdy, input int acc);
        bus.issue_valid   = v;
        bus.issue_type[0] = t0;
        bus.issue_type[1] = t1;
        bus.commit_ready  = rdy;
        if (acc > 0) begin exp_q.push_back('{t: t0, tag: itag_m}); itag_m = (itag_m + 1) % 16; end
        if (acc > 1) begin exp_q.push_back('{t: t1, tag: itag_m}); itag_m = (itag_m + 1) % 16; end
    endtask

    task automatic expect_s(input int cnt, input int emp, input int ful, input int inc,
                            input int ir, input int cv, input int tag0);
        stat_q.push_back('{cyc: cyc, cnt: cnt, emp: emp, ful: ful, inc: inc, ir: ir, cv: cv, tag0: tag0});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.issue_valid   = '0;
        bus.issue_type    = '{COMMIT_NULL, COMMIT_NULL};
        bus.commit_ready  = '0;
`ifdef COMMIT_RING_FLUSH_EN
        bus.flush_valid   = 1'b0;
        bus.flush_tag     = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // reset state, issue {GPR,FPR} at tags 0,1
        drive(2'b11, COMMIT_GPR, COMMIT_FPR, 2'b00, 2); expect_s(0, 1, 0, 0, 3, 0, 0); tick();
        // slot 0 not ready -> nothing retires
        drive(2'b00, COMMIT_NULL, COMMIT_NULL, 2'b10, 0); expect_s(2, 0, 0, 0, 3, 3, 2); tick();
        drive(2'b00, COMMIT_NULL, COMMIT_NULL, 2'b00, 0); expect_s(2, 0, 0, 0, 3, 3, 2); tick();
        drive(2'b00, COMMIT_NULL, COMMIT_NULL, 2'b11, 0); expect_s(2, 0, 0, 0, 3, 3, 2); tick();

        // fill all 16 entries, no commits
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) drive(2'b11, COMMIT_SW, COMMIT_OUT, 2'b00, 2);
            else            drive(2'b11, COMMIT_B,  COMMIT_X,   2'b00, 2);
            expect_s(2 * i, (i == 0) ? 1 : 0, 0, 0, 3, (i == 0) ? 0 : 3, (2 + 2 * i) % 16);
            tick();
        end
        // full: issue attempt rejected, retire 2
        drive(2'b11, COMMIT_GPR, COMMIT_GPR, 2'b11, 0); expect_s(16, 0, 1, 0, 0, 3, 2); tick();
        drive(2'b00, COMMIT_NULL, COMMIT_NULL, 2'b00, 0); expect_s(14, 0, 0, 0, 3, 3, 2); tick();
        // drain
        for (int i = 0; i < 7; i++) begin
            drive(2'b00, COMMIT_NULL, COMMIT_NULL, 2'b11, 0);
            expect_s(14 - 2 * i, 0, 0, 0, 3, 3, 2);
            tick();
        end

        // 10 input-class entries on the second lap (tags 2..11)
        for (int i = 0; i < 5; i++) begin
            drive(2'b11, COMMIT_GPR_IN, COMMIT_FPR_IN, 2'b00, 2);
            expect_s(2 * i, (i == 0) ? 1 : 0, 0, 2 * i, 3, (i == 0) ? 0 : 3, (2 + 2 * i) % 16);
            tick();
        end
        drive(2'b00, COMMIT_NULL, COMMIT_NULL, 2'b11, 0); expect_s(10, 0, 0, 10, 3, 3, 12); tick();
        drive(2'b00, COMMIT_NULL, COMMIT_NULL, 2'b11, 0); expect_s(8, 0, 0, 8, 3, 3, 12); tick();
        drive(2'b00, COMMIT_NULL, COMMIT_NULL, 2'b00, 0); expect_s(6, 0, 0, 6, 3, 3, 12); tick();

        // refill to full, then reset with commit_ready high
        for (int i = 0; i < 5; i++) begin
            drive(2'b11, COMMIT_GPR, COMMIT_OUT, 2'b00, 2);
            expect_s(6 + 2 * i, 0, 0, 6, 3, 3, (12 + 2 * i) % 16);
            tick();
        end
        drive(2'b00, COMMIT_NULL, COMMIT_NULL, 2'b11, 0); expect_s(16, 0, 1, 6, 0, 3, 6);
        reset_n = 1'b0;
        exp_q.delete();
        itag_m = 0;
        tick();
        reset_n = 1'b1;
        drive(2'b00, COMMIT_NULL, COMMIT_NULL, 2'b11, 0); expect_s(0, 1, 0, 0, 3, 0, 0); tick();
        drive(2'b00, COMMIT_NULL, COMMIT_NULL, 2'b00, 0); expect_s(0, 1, 0, 0, 3, 0, 0); tick();

`ifdef COMMIT_RING_FLUSH_EN
        // move head to tag 3, then 8 entries at tags 3..10
        drive(2'b11, COMMIT_GPR, COMMIT_GPR, 2'b00, 2);   expect_s(0, 1, 0, 0, 3, 0, 0); tick();
        drive(2'b01, COMMIT_GPR, COMMIT_NULL, 2'b00, 1);  expect_s(2, 0, 0, 0, 3, 3, 2); tick();
        drive(2'b00, COMMIT_NULL, COMMIT_NULL, 2'b11, 0); expect_s(3, 0, 0, 0, 3, 3, 3); tick();
        drive(2'b00, COMMIT_NULL, COMMIT_NULL, 2'b01, 0); expect_s(1, 0, 0, 0, 3, 1, 3); tick();
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, COMMIT_B, COMMIT_GPR_IN, 2'b00, 2);
            expect_s(2 * i, (i == 0) ? 1 : 0, 0, i, 3, (i == 0) ? 0 : 3, 3 + 2 * i);
            tick();
        end
        // flush at tag 5 while tag 3 retires; 6..10 squashed
        drive(2'b00, COMMIT_NULL, COMMIT_NULL, 2'b01, 0); expect_s(8, 0, 0, 4, 0, 3, 11);
        bus.flush_valid = 1'b1;
        bus.flush_tag   = 4'd5;
        repeat (5) void'(exp_q.pop_back());
        itag_m = 6;
        tick();
        bus.flush_valid = 1'b0;
        drive(2'b00, COMMIT_NULL, COMMIT_NULL, 2'b00, 0); expect_s(2, 0, 0, 1, 3, 3, 6); tick();
        drive(2'b00, COMMIT_NULL, COMMIT_NULL, 2'b11, 0); expect_s(2, 0, 0, 1, 3, 3, 6); tick();
        drive(2'b01, COMMIT_GPR, COMMIT_NULL, 2'b00, 1);  expect_s(0, 1, 0, 0, 3, 0, 6); tick();
        drive(2'b00, COMMIT_NULL, COMMIT_NULL, 2'b11, 0); expect_s(1, 0, 0, 0, 3, 1, 7); tick();
`endif

        drive(2'b00, COMMIT_NULL, COMMIT_NULL, 2'b00, 0);
        done = 1'b1;
        for (int i = 0; i < 10 && !mon_done; i++) @(posedge clk);
        if (!mon_done) begin
            $display("FAIL monitor_done: monitor did not complete within 10 cycles");
            $fatal(1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
